difftest_vec_wb_queue: RTL

- Collects vector-register writeback events from the core's NUM_PORTS writeback ports and buffers them in an in-order FIFO.
- Drains at most one event per cycle toward the difftest vector-writeback DPI stage.
- Sits directly upstream of that stage and drives its enable/valid/address/data/coreid inputs.
- Decouples multi-port, bursty writeback from the single-event-per-cycle difftest interface and flags lost events.

---
 rtl/difftest_vec_wb_queue_if.sv | 48 ++++
 rtl/difftest_vec_wb_queue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/difftest_vec_wb_queue_if.sv
// Bundle of writeback-queue signals between the core writeback ports, the
// queue and the downstream difftest vector-writeback stage.
//
// Handshake:
//   Input side: the queue advertises io_in_ready from its registered
//   occupancy only. A port's event is taken on a rising edge when its
//   io_in_valid bit is set and io_in_ready is 1. If io_in_ready is 0, every
//   valid port that cycle is dropped as a group.
//   Output side: the head entry is presented while io_out_valid is 1. It is
//   consumed on a rising edge when io_out_valid and io_out_ready are both 1.
//   io_out_enable is exactly that product. Head fields are meaningful only
//   while io_out_valid is 1.
interface difftest_vec_wb_queue_if #(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 7,
    parameter int DW        = 64
);
    logic [NUM_PORTS-1:0]    io_in_valid;
    logic [AW*NUM_PORTS-1:0] io_in_address;
    logic [DW*NUM_PORTS-1:0] io_in_data_0;
    logic [DW*NUM_PORTS-1:0] io_in_data_1;
    logic                    io_in_ready;
    logic [7:0]              io_coreid;
    logic                    io_out_ready;
    logic                    io_out_valid;
    logic                    io_out_enable;
    logic [AW-1:0]           io_out_address;
    logic [DW-1:0]           io_out_data_0;
    logic [DW-1:0]           io_out_data_1;
    logic [7:0]              io_out_coreid;
    logic                    io_overflow;

    // Queue side.
    modport slave (
        input  io_in_valid, io_in_address, io_in_data_0, io_in_data_1,
        input  io_coreid, io_out_ready,
        output io_in_ready, io_out_valid, io_out_enable, io_out_address,
        output io_out_data_0, io_out_data_1, io_out_coreid, io_overflow
    );

    // Environment side (writeback ports plus downstream stage).
    modport master (
        output io_in_valid, io_in_address, io_in_data_0, io_in_data_1,
        output io_coreid, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_enable, io_out_address,
        input  io_out_data_0, io_out_data_1, io_out_coreid, io_overflow
    );
endinterface

// File: rtl/difftest_vec_wb_queue.sv
// In-order FIFO collecting vector writeback events from NUM_PORTS ports and
// draining one event per cycle toward the difftest vector-writeback stage.
// A group that arrives while fewer than NUM_PORTS slots are free is dropped
// whole and the sticky overflow flag is raised.
//
// Optional build macro: DIFFTEST_VEC_WB_STATS_EN adds io_stat_events,
// io_stat_drops and io_stat_max_occ counters.
module difftest_vec_wb_queue #(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 8,
    parameter int AW        = 7,
    parameter int DW        = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    difftest_vec_wb_queue_if.slave      bus
`ifdef DIFFTEST_VEC_WB_STATS_EN
    ,
    output logic [31:0]                 io_stat_events,
    output logic [31:0]                 io_stat_drops,
    output logic [$clog2(DEPTH):0]      io_stat_max_occ
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]  mem_addr [DEPTH];
    logic [DW-1:0]  mem_d0   [DEPTH];
    logic [DW-1:0]  mem_d1   [DEPTH];

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic [CW-1:0]  valid_cnt;
    logic [CW-1:0]  accepted;
    logic [PW-1:0]  wr_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] wr_en;
    logic           in_ready;
    logic           deq;
    logic           overflow;
    logic [7:0]     coreid_q;

    // Room for a whole group is judged from the registered count alone, so
    // io_in_ready never depends on io_out_ready.
    assign in_ready = (CW'(DEPTH) - count) >= CW'(NUM_PORTS);

    // Pack the valid ports into consecutive slots from wr_ptr in port order.
    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            wr_idx[i] = wr_ptr + PW'(valid_cnt);
            wr_en[i]  = in_ready && bus.io_in_valid[i];
            if (bus.io_in_valid[i]) begin
                valid_cnt = valid_cnt + CW'(1);
            end
        end
    end

    assign accepted   = in_ready ? valid_cnt : '0;
    assign deq        = (count != '0) && bus.io_out_ready;
    assign count_next = count + accepted - CW'(deq);

    assign bus.io_in_ready    = in_ready;
    assign bus.io_out_valid   = (count != '0);
    assign bus.io_out_enable  = deq;
    assign bus.io_out_address = mem_addr[rd_ptr];
    assign bus.io_out_data_0  = mem_d0[rd_ptr];
    assign bus.io_out_data_1  = mem_d1[rd_ptr];
    assign bus.io_out_coreid  = coreid_q;
    assign bus.io_overflow    = overflow;

    // Entry storage: written only for accepted ports, never reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_en[i]) begin
                mem_addr[wr_idx[i]] <= bus.io_in_address[AW*i +: AW];
                mem_d0[wr_idx[i]]   <= bus.io_in_data_0[DW*i +: DW];
                mem_d1[wr_idx[i]]   <= bus.io_in_data_1[DW*i +: DW];
            end
        end
    end

    // Pointers, occupancy, sticky overflow and the registered core id.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            coreid_q <= '0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(accepted);
            rd_ptr   <= rd_ptr + PW'(deq);
            count    <= count_next;
            overflow <= overflow || (!in_ready && (|bus.io_in_valid));
            coreid_q <= bus.io_coreid;
        end
    end

`ifdef DIFFTEST_VEC_WB_STATS_EN
    logic [CW-1:0] drop_cnt;
    logic [32:0]   drop_sum;

    assign drop_cnt = in_ready ? '0 : valid_cnt;
    assign drop_sum = {1'b0, io_stat_drops} + 33'(drop_cnt);

    // Saturating event/drop counters and occupancy high-water mark.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_stat_events  <= '0;
            io_stat_drops   <= '0;
            io_stat_max_occ <= '0;
        end else begin
            if (deq && (io_stat_events != '1)) begin
                io_stat_events <= io_stat_events + 32'd1;
            end
            io_stat_drops <= drop_sum[32] ? '1 : drop_sum[31:0];
            if (count_next > io_stat_max_occ) begin
                io_stat_max_occ <= count_next;
            end
        end
    end
`endif

endmodule
